// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux select arbiter: channel count, select width,
// FSM states and the default hold limit.
package mux_sel_arbiter_pkg;

  localparam int NUM_CH       = 4;
  localparam int SEL_W        = 2;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request after ptr, wrapping,
// with ptr itself checked last.
module rr_pick
  import mux_sel_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects, with a bounded hold time
// per owner whenever another channel is waiting.
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] REQ,
  output logic              S1,
  output logic              S0,
  output logic [NUM_CH-1:0] GNT,
  output logic              VALID
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t           state, state_n;
  logic [SEL_W-1:0] owner, owner_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [7:0]       hold_cnt, hold_n;
  logic [SEL_W-1:0] pick_ptr, pick_idx;
  logic             pick_any, others_req, rel;

  // While granted the search starts after the current owner, so the owner
  // is considered last and never wins its own re-grant under contention.
  assign pick_ptr   = (state == GRANT) ? owner : ptr;
  assign others_req = |(REQ & ~onehot(owner));

  rr_pick u_pick (
    .req (REQ),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= 2'd3;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    rel     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_n = GRANT;
          owner_n = pick_idx;
          hold_n  = '0;
        end
      end
      GRANT: begin
        rel = !REQ[owner] || ((hold_cnt == HOLD_LAST) && others_req);
        if (rel) begin
          ptr_n  = owner;
          hold_n = '0;
          if (others_req) begin
            owner_n = pick_idx;
          end else begin
            state_n = IDLE;
          end
        end else begin
          // A lone owner never expires; the counter just wraps.
          hold_n = (hold_cnt == HOLD_LAST) ? '0 : hold_cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode straight from flops; selects keep the last owner when idle.
  assign GNT     = (state == GRANT) ? onehot(owner) : '0;
  assign VALID   = (state == GRANT);
  assign {S1, S0} = owner;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench: two arbiters (MAX_HOLD 8 and 1) share one request bus
// and are compared each cycle against an integer-level round-robin model.
module tb_mux_sel_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req   = 4'b0000;

  logic       s1a, s0a, valida;
  logic [3:0] gnta;
  logic       s1b, s0b, validb;
  logic [3:0] gntb;

  int total = 0;
  int bad   = 0;

  int maxHold [2] = '{8, 1};
  int mOwner  [2];
  int mPtr    [2];
  int mHeld   [2];
  int mSel    [2];

  always #5 clk = ~clk;

  mux_sel_arbiter dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .REQ   (req),
    .S1    (s1a),
    .S0    (s0a),
    .GNT   (gnta),
    .VALID (valida)
  );

  mux_sel_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .REQ   (req),
    .S1    (s1b),
    .S0    (s0b),
    .GNT   (gntb),
    .VALID (validb)
  );

  function automatic int pickFrom(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mOwner[d] = -1;
      mPtr[d]   = 3;
      mHeld[d]  = 0;
      mSel[d]   = 0;
    end
  endtask

  // One clock edge of the arbitration rules; mHeld counts cycles of ownership.
  task automatic modelStep(input int d, input logic [3:0] r);
    logic [3:0] others;
    if (mOwner[d] < 0) begin
      if (r != 4'b0000) begin
        mOwner[d] = pickFrom(r, mPtr[d]);
        mHeld[d]  = 1;
      end
    end else begin
      others = r;
      others[mOwner[d]] = 1'b0;
      if (!r[mOwner[d]] || (mHeld[d] >= maxHold[d] && others != 4'b0000)) begin
        mPtr[d] = mOwner[d];
        if (others != 4'b0000) begin
          mOwner[d] = pickFrom(others, mPtr[d]);
          mHeld[d]  = 1;
        end else begin
          mOwner[d] = -1;
        end
      end else begin
        mHeld[d] = (mHeld[d] >= maxHold[d]) ? 1 : mHeld[d] + 1;
      end
    end
    if (mOwner[d] >= 0) mSel[d] = mOwner[d];
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] obsG, expG;
    logic       obsV, expV;
    logic [1:0] obsS, expS;
    for (int d = 0; d < 2; d++) begin
      obsG = (d == 0) ? gnta : gntb;
      obsV = (d == 0) ? valida : validb;
      obsS = (d == 0) ? {s1a, s0a} : {s1b, s0b};
      expG = 4'b0000;
      if (mOwner[d] >= 0) expG[mOwner[d]] = 1'b1;
      expV = (mOwner[d] >= 0);
      expS = 2'(mSel[d]);
      total++;
      assert (obsG === expG) else begin
        bad++;
        $error("[TB] FAIL %s gnt dut%0d: got %b want %b", tag, d, obsG, expG);
      end
      total++;
      assert (obsV === expV) else begin
        bad++;
        $error("[TB] FAIL %s valid dut%0d: got %b want %b", tag, d, obsV, expV);
      end
      total++;
      assert (obsS === expS) else begin
        bad++;
        $error("[TB] FAIL %s sel dut%0d: got %b want %b", tag, d, obsS, expS);
      end
    end
  endtask

  // Drive at the falling edge, optionally with a glitch that settles before the
  // rising edge, then advance the model and check at the next falling edge.
  task automatic applyStimulus(input logic [3:0] r, input bit glitch, input string tag);
    if (glitch) begin
      req = 4'($urandom);
      #2;
    end
    req = r;
    @(posedge clk);
    for (int d = 0; d < 2; d++) modelStep(d, r);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    logic [3:0] r;
    modelReset();
    #1 rst_n = 1'b0;
    #2 checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("reset_release");

    for (int i = 0; i < 20; i++) applyStimulus(4'b0100, 1'b0, "single_ch2");
    for (int i = 0; i < 3; i++)  applyStimulus(4'b0000, 1'b0, "drop_idle");
    for (int i = 0; i < 4; i++)  applyStimulus(4'b0101, 1'b0, "after_idle");
    for (int i = 0; i < 3; i++)  applyStimulus(4'b0000, 1'b0, "drain");
    for (int i = 0; i < 40; i++) applyStimulus(4'b1111, 1'b0, "full_load");
    for (int i = 0; i < 3; i++)  applyStimulus(4'b0000, 1'b0, "drain");
    for (int i = 0; i < 3; i++)  applyStimulus(4'b0010, 1'b0, "owner1");
    for (int i = 0; i < 12; i++) applyStimulus(4'b1001, 1'b0, "jump_to3");

    #1 rst_n = 1'b0;
    modelReset();
    #1 checkOutput("async_reset");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)  applyStimulus(4'b1010, 1'b0, "post_reset");
    for (int i = 0; i < 3; i++)  applyStimulus(4'b0000, 1'b0, "drain");
    for (int i = 0; i < 20; i++) applyStimulus(4'b0011, 1'b0, "pair_load");

    r = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      applyStimulus(r, ($urandom_range(0, 3) == 0), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

- Round-robin arbiter that drives the select lines of the 4-to-1 data multiplexer.
- Four requesters raise `REQ` bits; the block grants one channel at a time and presents its index on `S1`/`S0`.
- A one-hot `GNT` tells the winner its data is being passed; `VALID` qualifies the mux output.
- Sits directly upstream of the mux and consumes nothing but requests.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one owner keeps the grant while another channel is requesting. Legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `REQ` in 4: per-channel request; bit n belongs to mux input In.
- `S1` out 1: select MSB, registered.
- `S0` out 1: select LSB, registered.
- `GNT` out 4: one-hot grant, registered; all zero when idle.
- `VALID` out 1: high when a grant is active, i.e. the mux output is meaningful.

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: owner held in a 2-bit register.
- Internal state:
  - `ptr`: 2-bit last-served channel index.
  - `hold_cnt`: 8-bit hold counter.
- Reset values (asynchronous, immediate):
  - state=IDLE, `ptr`=3, `hold_cnt`=0.
  - `GNT`=0000, `VALID`=0, `S1`=0, `S0`=0.
- Pick function: the first set bit of `REQ`, searching ptr+1, ptr+2, ptr+3, ptr (mod 4). With ptr=3 after reset, channel 0 has top priority.
- IDLE:
  - `REQ`=0000: stay in IDLE.
  - Otherwise: go to GRANT with owner=pick, `GNT`=onehot(owner), {`S1`,`S0`}=owner, `VALID`=1, `hold_cnt`=0.
- GRANT, each cycle, evaluated in this order:
  - Release when `REQ[owner]`=0, or when `hold_cnt`=MAX_HOLD-1 and another `REQ` bit is set.
  - On release: `ptr`<=owner. If any other `REQ` bit is set, re-grant the pick winner on the same edge (no idle bubble) and set `hold_cnt`=0. Otherwise go to IDLE with `GNT`=0000 and `VALID`=0.
  - No release: `hold_cnt` increments. At MAX_HOLD-1 with no competitor it wraps to 0 and the owner keeps the grant.
- `S1`/`S0` retain the last owner index while IDLE; downstream must qualify with `VALID`.
- The owner is never re-granted on expiry while a competitor exists, because the pick places the owner last.
- Invariants:
  - `GNT` is one-hot or zero.
  - `VALID` equals |`GNT`.
  - {`S1`,`S0`} equals the index of the set `GNT` bit whenever `VALID`=1.

## Timing
- Outputs are registered; there is no combinational path from `REQ` to any output.
- Request-to-grant latency is 1 cycle: a `REQ` sampled at edge k makes `GNT` visible after edge k.
- Release latency is 1 cycle: owner deasserts `REQ` before edge k, and `GNT` moves or clears after edge k.
- Under contention the owner holds the grant exactly MAX_HOLD cycles, then rotates.
- MAX_HOLD=1 rotates every cycle under full load.
- Simultaneous owner drop and expiry: treated as a single release; `ptr`=owner.
- `REQ` changes while IDLE are sampled only at the edge.
- Glitches between edges are ignored.
- `rst_n` asserted mid-grant clears all outputs immediately, without waiting for a clock edge.
- After `rst_n` deasserts, the first grant follows reset priority (channel 0 first).

## Structure
- Shared package contains:
  - `NUM_CH`=4 and `SEL_W`=2.
  - State enum {IDLE, GRANT}.
  - The `MAX_HOLD` default.
- One sub-module, `rr_pick`: combinational; inputs `REQ`[3:0] and `ptr`[1:0]; outputs `idx`[1:0] and `any`. Reused for both the IDLE pick and the re-grant pick.
- Top level holds:
  - state, owner, `ptr`, `hold_cnt`;
  - the output registers;
  - a direct one-hot encoder from owner.

## Test plan
- Reset then `REQ`=0100 held → one cycle later `GNT`=0100, `S1`=1, `S0`=0, `VALID`=1; the grant stays with no rotation indefinitely.
- `REQ`=1111 held, MAX_HOLD=8 → owners 0,1,2,3,0… with each owner's `GNT` lasting exactly 8 cycles and no cycle with `VALID`=0.
- Owner 1 granted, `REQ` changes from 0010 to 1001 at once → next cycle `GNT`=1000 (search from 2 finds 3), `hold_cnt` restarts.
- Owner 2 alone, `REQ` drops to 0000 → next cycle `GNT`=0000, `VALID`=0, `S1`=1, `S0`=0 retained; a later `REQ`=0101 grants channel 0 (search starts at 3).
- `rst_n` pulsed low mid-grant between clock edges → `GNT`=0000, `VALID`=0, `S1`=`S0`=0 immediately; after release with `REQ`=1010, channel 1 is granted first.
- MAX_HOLD=1, `REQ`=0011 → `GNT` alternates 0001/0010 every cycle; the one-hot/`VALID`/select invariants hold every cycle.
